// File: rtl/complex_mult_axis.sv
// complex_mult_axis: streaming complex multiplier, valid/ready handshake,
// per-beat conjugate, round-half-up fixed-point scaling.
// Optional feature macro: CMULT_SAT_EN (defined: saturate outputs and raise
// sticky ovf; undefined: wrap to DW_OUT bits, ovf tied low).
// Latency: a beat accepted at edge N is presented after edge N+PIPE_NUM
// (one operand register plus PIPE_NUM result stages).
module complex_mult_axis #(
  parameter int unsigned DW_IN    = 16,
  parameter int unsigned DW_OUT   = 16,
  parameter int unsigned SHIFT    = 15,
  parameter int unsigned PIPE_NUM = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     s_valid,
  output logic                     s_ready,
  input  logic signed [DW_IN-1:0]  s_a_re,
  input  logic signed [DW_IN-1:0]  s_a_im,
  input  logic signed [DW_IN-1:0]  s_b_re,
  input  logic signed [DW_IN-1:0]  s_b_im,
  input  logic                     s_conj,
  input  logic                     s_last,
  output logic                     m_valid,
  input  logic                     m_ready,
  output logic        [DW_OUT-1:0] m_re,
  output logic        [DW_OUT-1:0] m_im,
  output logic                     m_last,
  output logic                     ovf,
  input  logic                     ovf_clr
);

  localparam int unsigned PW = 2 * DW_IN;  // product width
  localparam int unsigned RW = PW + 2;     // sum width plus rounding headroom

  localparam logic        [RW-1:0] RND_ONE = RW'(1);
  localparam logic signed [RW-1:0] RND     = signed'((RND_ONE << SHIFT) >> 1);

  typedef struct packed {
    logic              v;
    logic [DW_OUT-1:0] re;
    logic [DW_OUT-1:0] im;
    logic              of;
    logic              last;
  } stage_t;

  logic adv;
  assign adv     = ~m_valid | m_ready;
  assign s_ready = adv;

  logic                    op_v;
  logic signed [DW_IN-1:0] op_a_re, op_a_im, op_b_re, op_b_im;
  logic                    op_conj, op_last;

  // Operand capture register; the whole pipeline advances together on adv
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_v    <= 1'b0;
      op_a_re <= '0;
      op_a_im <= '0;
      op_b_re <= '0;
      op_b_im <= '0;
      op_conj <= 1'b0;
      op_last <= 1'b0;
    end else if (adv) begin
      op_v    <= s_valid;
      op_a_re <= s_a_re;
      op_a_im <= s_a_im;
      op_b_re <= s_b_re;
      op_b_im <= s_b_im;
      op_conj <= s_conj;
      op_last <= s_last;
    end
  end

  logic signed [PW-1:0] p_rr, p_ii, p_ri, p_ir;
  logic signed [RW-1:0] sum_re, sum_im, rnd_re, rnd_im, sh_re, sh_im;

  assign p_rr = PW'(op_a_re) * PW'(op_b_re);
  assign p_ii = PW'(op_a_im) * PW'(op_b_im);
  assign p_ri = PW'(op_a_re) * PW'(op_b_im);
  assign p_ir = PW'(op_a_im) * PW'(op_b_re);

  assign sum_re = op_conj ? (RW'(p_rr) + RW'(p_ii)) : (RW'(p_rr) - RW'(p_ii));
  assign sum_im = op_conj ? (RW'(p_ir) - RW'(p_ri)) : (RW'(p_ri) + RW'(p_ir));

  // RND is zero when SHIFT is zero, so no rounding is applied then
  assign rnd_re = sum_re + RND;
  assign rnd_im = sum_im + RND;
  assign sh_re  = rnd_re >>> SHIFT;
  assign sh_im  = rnd_im >>> SHIFT;

  logic [DW_OUT-1:0] nar_re, nar_im;
  logic              nar_of;

`ifdef CMULT_SAT_EN
  localparam logic [DW_OUT-1:0] SAT_MAX = {1'b0, {(DW_OUT-1){1'b1}}};
  localparam logic [DW_OUT-1:0] SAT_MIN = {1'b1, {(DW_OUT-1){1'b0}}};

  logic [RW-DW_OUT:0] hi_re, hi_im;
  logic               of_re, of_im;

  // Out of range when the bits above the output sign are not a pure sign extension
  assign hi_re  = sh_re[RW-1:DW_OUT-1];
  assign hi_im  = sh_im[RW-1:DW_OUT-1];
  assign of_re  = ~((&hi_re) | ~(|hi_re));
  assign of_im  = ~((&hi_im) | ~(|hi_im));
  assign nar_re = of_re ? (sh_re[RW-1] ? SAT_MIN : SAT_MAX) : sh_re[DW_OUT-1:0];
  assign nar_im = of_im ? (sh_im[RW-1] ? SAT_MIN : SAT_MAX) : sh_im[DW_OUT-1:0];
  assign nar_of = of_re | of_im;
`else
  assign nar_re = sh_re[DW_OUT-1:0];
  assign nar_im = sh_im[DW_OUT-1:0];
  assign nar_of = 1'b0;
`endif

  stage_t st [PIPE_NUM];

  // First result stage registers the narrowed product
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st[0] <= '0;
    end else if (adv) begin
      st[0] <= '{v: op_v, re: nar_re, im: nar_im, of: nar_of, last: op_last};
    end
  end

  // Remaining delay stages; bubbles shift through like beats
  for (genvar g = 1; g < PIPE_NUM; g++) begin : g_pipe
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        st[g] <= '0;
      end else if (adv) begin
        st[g] <= st[g-1];
      end
    end
  end

  assign m_valid = st[PIPE_NUM-1].v;
  assign m_re    = st[PIPE_NUM-1].re;
  assign m_im    = st[PIPE_NUM-1].im;
  assign m_last  = st[PIPE_NUM-1].last;

`ifdef CMULT_SAT_EN
  // Sticky overflow, set only on a transferred beat; clear wins over set
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf <= 1'b0;
    end else if (ovf_clr) begin
      ovf <= 1'b0;
    end else if (m_valid && m_ready && st[PIPE_NUM-1].of) begin
      ovf <= 1'b1;
    end
  end
`else
  assign ovf = 1'b0;

  logic unused_wrap;
  assign unused_wrap = &{1'b0, ovf_clr, st[PIPE_NUM-1].of,
                         sh_re[RW-1:DW_OUT], sh_im[RW-1:DW_OUT]};
`endif

endmodule
